// File: rtl/chan_550_ser_di_ctrl.sv
// Serial-programming sequencer: turns a toggle-qualified command word into an
// MSB-first 3-wire transfer (sclk / sdata / one-hot latch enable) to one of four devices.
module chan_550_ser_di_ctrl #(
  parameter int DATA_W    = 24,
  parameter int CLK_DIV   = 4,
  parameter int LE_CYCLES = 2
) (
  input  logic        user_clk,
  input  logic        user_rst_n,
  input  logic [31:0] reg_data,
  output logic        sclk,
  output logic        sdata,
  output logic [3:0]  le,
  output logic [31:0] status_word
);

  localparam int SW = DATA_W + 3;
  localparam logic [4:0]  LAST_BIT = 5'(DATA_W - 1);
  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] LE_LAST  = 16'(LE_CYCLES - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_LO    = 3'd2;
  localparam logic [2:0] S_HI    = 3'd3;
  localparam logic [2:0] S_LATCH = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;

  // Only the toggle, select and payload bits are carried through the two stages.
  logic [SW-1:0]     stage_a;
  logic [SW-1:0]     stage_b;
  logic              tog_ack;
  logic [DATA_W+1:0] pend_word;
  logic              pending;
  logic              overrun;
  logic [1:0]        cur_sel;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_sh;
  logic [4:0]        bit_cnt;
  logic [15:0]       tmr;
  logic [15:0]       done_cnt;
  logic [2:0]        state;
  logic [2:0]        state_next;
  logic              accept;
  logic              tmr_end;
  logic [DATA_W+1:0] in_word;
  logic              unused_bits;

  assign unused_bits = ^reg_data;
  assign accept   = (stage_a[SW-1] == stage_b[SW-1]) && (stage_b[SW-1] != tog_ack);
  assign in_word  = stage_b[SW-2:0];
  assign shreg_sh = shreg << 1;

  always_comb begin
    tmr_end = 1'b0;
    case (state)
      S_LO, S_HI: tmr_end = (tmr == DIV_LAST);
      S_LATCH:    tmr_end = (tmr == LE_LAST);
      default:    tmr_end = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (pending || accept) state_next = S_LOAD;
      S_LOAD:  state_next = S_LO;
      S_LO:    if (tmr_end) state_next = S_HI;
      S_HI:    if (tmr_end) state_next = (bit_cnt == 5'd0) ? S_LATCH : S_LO;
      S_LATCH: if (tmr_end) state_next = S_GAP;
      S_GAP:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      stage_a   <= '0;
      stage_b   <= '0;
      tog_ack   <= 1'b0;
      pend_word <= '0;
      pending   <= 1'b0;
      overrun   <= 1'b0;
      cur_sel   <= 2'd0;
      shreg     <= '0;
      bit_cnt   <= 5'd0;
      tmr       <= 16'd0;
      done_cnt  <= 16'd0;
      state     <= S_IDLE;
      sclk      <= 1'b0;
      sdata     <= 1'b0;
      le        <= 4'd0;
    end else begin
      stage_a <= {reg_data[31], reg_data[29:28], reg_data[DATA_W-1:0]};
      stage_b <= stage_a;
      state   <= state_next;
      tmr     <= (state_next != state) ? 16'd0 : tmr + 16'd1;

      if (accept) tog_ack <= stage_b[SW-1];

      // A freed pending slot can take a request arriving on the same IDLE cycle.
      if (state == S_IDLE) begin
        if (pending) begin
          {cur_sel, shreg} <= pend_word;
          pending          <= accept;
          if (accept) pend_word <= in_word;
        end else if (accept) begin
          {cur_sel, shreg} <= in_word;
        end
      end else if (accept) begin
        if (pending) begin
          overrun <= 1'b1;
        end else begin
          pending   <= 1'b1;
          pend_word <= in_word;
        end
      end

      if (state == S_LOAD) begin
        sdata   <= shreg[DATA_W-1];
        bit_cnt <= LAST_BIT;
      end
      if (state == S_HI && tmr_end && bit_cnt != 5'd0) begin
        shreg   <= shreg_sh;
        sdata   <= shreg_sh[DATA_W-1];
        bit_cnt <= bit_cnt - 5'd1;
      end
      if (state_next == S_GAP) sdata <= 1'b0;

      // Outputs are registered from the next state so they line up with the state register.
      sclk <= (state_next == S_HI);
      le   <= (state_next == S_LATCH) ? 4'(4'b0001 << cur_sel) : 4'd0;

      if (state == S_GAP) done_cnt <= done_cnt + 16'd1;
    end
  end

  assign status_word = {done_cnt, 13'd0, overrun, pending, (state != S_IDLE)};

endmodule
